multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Issue/retire controller between the execute stage and the multicycle mult/div units (the divider's operandA/operandB/resultRDY/exception interface).
- Latches a mult or div request, drives stable operands, and pulses a one-cycle start.
- Stalls the pipeline until the unit reports ready, then presents the result to writeback with a valid/ready handshake.
- Converts unit exceptions into an rstatus write and guards against a unit that never reports ready.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, destination register index width
TIMEOUT, 64, max BUSY cycles before forced abort (>=2)
STATUS_REG, 30, rstatus register index written on exception
MULT_EXC_CODE, 4, value written to rstatus on mult overflow
DIV_EXC_CODE, 5, value written to rstatus on divide-by-zero

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  1  execute stage holds a mult/div op
req_is_div  in  1  1=div, 0=mult
req_opA  in  DATA_W  operand A
req_opB  in  DATA_W  operand B
req_rd  in  REG_W  destination register
stall  out  1  freeze upstream pipeline
unit_operandA  out  DATA_W  latched operand A to mult and div
unit_operandB  out  DATA_W  latched operand B to mult and div
ctrl_mult  out  1  one-cycle mult start pulse
ctrl_div  out  1  one-cycle div start pulse
unit_result  in  DATA_W  result from selected unit
unit_exception  in  1  exception from selected unit
unit_resultRDY  in  1  result-ready from selected unit
res_valid  out  1  result available to writeback
res_ready  in  1  writeback accepts result
res_data  out  DATA_W  write data
res_rd  out  REG_W  write register
res_exception  out  1  result is an exception/rstatus write
timeout_err  out  1  sticky: a timeout abort occurred

Behaviour:
- Reset (async, any state): state=IDLE. All registered outputs, operand latches, result latches, counter and timeout_err are 0. Combinational outputs evaluate to 0 in IDLE with req_valid=0.
- FSM states are IDLE, START, BUSY, DONE.
- IDLE:
  - If req_valid=1 at the edge: latch opA, opB, rd and is_div, then go to START.
  - stall = req_valid (combinational).
- START:
  - Exactly one of ctrl_mult/ctrl_div = 1 for this single cycle, chosen by the latched is_div.
  - stall=1. unit_resultRDY is ignored as stale.
  - Next state is BUSY; the counter clears to 0.
- BUSY:
  - stall=1; the counter increments each cycle.
  - On unit_resultRDY=1: capture into the result latches, then go to DONE.
    - If unit_exception=0: res_data=unit_result, res_rd=latched rd, res_exception=0.
    - If unit_exception=1: res_data = DIV_EXC_CODE (div) or MULT_EXC_CODE (mult), res_rd=STATUS_REG, res_exception=1.
  - Else if the counter reaches TIMEOUT-1: go to DONE as an exception (code per op, rd=STATUS_REG) and set timeout_err.
  - RDY and timeout in the same cycle: RDY wins.
- DONE:
  - res_valid=1; res_data, res_rd and res_exception are held stable.
  - stall = ~res_ready.
  - When res_ready=1 at the edge, go to IDLE. A req_valid in that cycle is not accepted; it is accepted from IDLE next cycle.
- unit_operandA/B stay at the latched values from START through DONE. They change only on acceptance in IDLE.
- unit_resultRDY and unit_exception are ignored in IDLE, START and DONE.
- Latency, request accepted at edge 0:
  - start pulse in cycle 1;
  - BUSY from cycle 2;
  - res_valid in the cycle after RDY is seen.
- timeout_err clears only on reset.
- Reset mid-operation: immediate return to IDLE, no result is produced, and no start pulse is issued after reset deasserts until a new request arrives.

Decomposition:
- Shared package: FSM state encoding (IDLE/START/BUSY/DONE), MULT_EXC_CODE/DIV_EXC_CODE, STATUS_REG, and the default DATA_W/REG_W.
- One sub-module: md_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired at TIMEOUT-1.
  - Shares the same asynchronous active-high reset.

Test Plan:
- Div 21/3, rd=7: ctrl_div pulses exactly once; unit returns 7 with RDY → res_valid with res_data=7, res_rd=7, res_exception=0; stall drops in the cycle res_ready=1.
- Div 10/0: unit_exception=1 with RDY → res_data=5, res_rd=30, res_exception=1.
- Mult 0x40000000×4 with overflow: unit_exception=1 → res_data=4, res_rd=30, ctrl_mult pulsed and ctrl_div never high.
- Backpressure: res_ready held low 3 cycles in DONE → res_* stable, stall=1 throughout, single acceptance; a back-to-back request is accepted 1 cycle after DONE exits.
- Timeout: RDY never asserted with TIMEOUT=8 → DONE 8 cycles after BUSY entry, rd=30, timeout_err=1 and still 1 after the next normal op.
- Reset pulsed mid-BUSY: outputs 0 asynchronously; a late RDY is ignored; no res_valid until a new request completes.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl_pkg
// Purpose  : Shared definitions for the mult/div issue controller.
//            Contains the FSM state encoding, default widths, the rstatus
//            register index and the exception codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multdiv_issue_ctrl_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_REG_W         = 5;
  localparam int DEF_TIMEOUT       = 64;
  localparam int DEF_STATUS_REG    = 30;
  localparam int DEF_MULT_EXC_CODE = 4;
  localparam int DEF_DIV_EXC_CODE  = 5;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : multdiv_issue_ctrl_pkg
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl_if
// Purpose  : Bundles the execute-stage request, the mult/div unit interface
//            and the writeback handshake of the issue controller.
// Modports : master - the issue controller
//            slave  - the surrounding pipeline / units
// Revision : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  // execute-stage request
  logic              req_valid;
  logic              req_is_div;
  logic [DATA_W-1:0] req_opA;
  logic [DATA_W-1:0] req_opB;
  logic [REG_W-1:0]  req_rd;
  logic              stall;

  // multicycle unit side
  logic [DATA_W-1:0] unit_operandA;
  logic [DATA_W-1:0] unit_operandB;
  logic              ctrl_mult;
  logic              ctrl_div;
  logic [DATA_W-1:0] unit_result;
  logic              unit_exception;
  logic              unit_resultRDY;

  // writeback side
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [REG_W-1:0]  res_rd;
  logic              res_exception;
  logic              timeout_err;

  modport master (
    input  req_valid, req_is_div, req_opA, req_opB, req_rd,
    input  unit_result, unit_exception, unit_resultRDY, res_ready,
    output stall, unit_operandA, unit_operandB, ctrl_mult, ctrl_div,
    output res_valid, res_data, res_rd, res_exception, timeout_err
  );

  modport slave (
    output req_valid, req_is_div, req_opA, req_opB, req_rd,
    output unit_result, unit_exception, unit_resultRDY, res_ready,
    input  stall, unit_operandA, unit_operandB, ctrl_mult, ctrl_div,
    input  res_valid, res_data, res_rd, res_exception, timeout_err
  );

endinterface : multdiv_issue_ctrl_if
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_md_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : md_timeout_counter
// Purpose  : Counts cycles spent waiting on a multicycle unit and flags when
//            the wait reaches TIMEOUT-1.
// Ports    : clock, reset (async, active-high)
//            clear   - synchronous clear to 0 (has priority over enable)
//            enable  - increment by one this cycle
//            expired - count equals TIMEOUT-1
// Revision : 1.0 - initial release
// ============================================================================
module md_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // TIMEOUT >= 2, so TIMEOUT-1 always fits in $clog2(TIMEOUT) bits
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule : md_timeout_counter
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl
// Purpose  : Issue/retire controller between execute and the multicycle
//            mult/div units. Latches a request, pulses a one-cycle start,
//            stalls until the unit is ready (or a timeout expires), then
//            offers the result to writeback with a valid/ready handshake.
//            Unit exceptions and timeouts become an rstatus write.
// Ports    : clock, reset (async, active-high)
//            bus - multdiv_issue_ctrl_if.master (request, unit, writeback)
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int REG_W         = DEF_REG_W,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int STATUS_REG    = DEF_STATUS_REG,
  parameter int MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_issue_ctrl_if.master bus
);

  state_t            state;
  state_t            next_state;

  logic              is_div_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] opA_q;
  logic [DATA_W-1:0] opB_q;
  logic [DATA_W-1:0] res_data_q;
  logic [REG_W-1:0]  res_rd_q;
  logic              res_exc_q;
  logic              timeout_q;

  logic              expired;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              stall;
  logic              ctrl_mult;
  logic              ctrl_div;
  logic              res_valid;
  logic [DATA_W-1:0] exc_code;

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a ready result beats a simultaneous timeout
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) next_state = ST_START;
      ST_START: next_state = ST_BUSY;
      ST_BUSY:  if (bus.unit_resultRDY || expired) next_state = ST_DONE;
      ST_DONE:  if (bus.res_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall      = 1'b0;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    res_valid  = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      ST_IDLE:  stall = bus.req_valid;
      ST_START: begin
        stall     = 1'b1;
        ctrl_mult = ~is_div_q;
        ctrl_div  = is_div_q;
        cnt_clear = 1'b1;
      end
      ST_BUSY: begin
        stall      = 1'b1;
        cnt_enable = 1'b1;
      end
      ST_DONE: begin
        stall     = ~bus.res_ready;
        res_valid = 1'b1;
      end
      default: stall = 1'b0;
    endcase
  end

  assign exc_code = is_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);

  // Request and result latches; operands only change on acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_q   <= 1'b0;
      rd_q       <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_exc_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) begin
        is_div_q <= bus.req_is_div;
        rd_q     <= bus.req_rd;
        opA_q    <= bus.req_opA;
        opB_q    <= bus.req_opB;
      end
      if (state == ST_BUSY) begin
        if (bus.unit_resultRDY) begin
          if (bus.unit_exception) begin
            res_data_q <= exc_code;
            res_rd_q   <= REG_W'(STATUS_REG);
            res_exc_q  <= 1'b1;
          end else begin
            res_data_q <= bus.unit_result;
            res_rd_q   <= rd_q;
            res_exc_q  <= 1'b0;
          end
        end else if (expired) begin
          res_data_q <= exc_code;
          res_rd_q   <= REG_W'(STATUS_REG);
          res_exc_q  <= 1'b1;
          timeout_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.stall         = stall;
  assign bus.ctrl_mult     = ctrl_mult;
  assign bus.ctrl_div      = ctrl_div;
  assign bus.unit_operandA = opA_q;
  assign bus.unit_operandB = opB_q;
  assign bus.res_valid     = res_valid;
  assign bus.res_data      = res_data_q;
  assign bus.res_rd        = res_rd_q;
  assign bus.res_exception = res_exc_q;
  assign bus.timeout_err   = timeout_q;

endmodule : multdiv_issue_ctrl
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_issue_ctrl
// Purpose  : Self-checking bench for multdiv_issue_ctrl. A driver plays both
//            the execute stage and the mult/div unit; expected writeback
//            results are queued and a separate monitor compares them at each
//            writeback handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TMO    = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  multdiv_issue_ctrl_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  multdiv_issue_ctrl #(
    .DATA_W        (DATA_W),
    .REG_W         (REG_W),
    .TIMEOUT       (TMO),
    .STATUS_REG    (30),
    .MULT_EXC_CODE (4),
    .DIV_EXC_CODE  (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              exc;
  } res_t;

  res_t exp_q[$];
  int   n_vec    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  logic exp_terr = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: counts start pulses, checks result stability while held and
  // compares each accepted result with the scoreboard.
  res_t held;
  bit   holding = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      holding = 1'b0;
    end else begin
      if (bus.ctrl_mult) pulses++;
      if (bus.ctrl_div)  pulses++;
      if (bus.res_valid) begin
        if (holding) begin
          check("hold_data", bus.res_data, held.data);
          check("hold_rd",   bus.res_rd,   held.rd);
          check("hold_exc",  bus.res_exception, held.exc);
        end else begin
          held    = '{bus.res_data, bus.res_rd, bus.res_exception};
          holding = 1'b1;
        end
        if (bus.res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got data 0x%0h, expected no result", bus.res_data);
          end else begin
            res_t e;
            e = exp_q.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_rd",   bus.res_rd,   e.rd);
            check("res_exc",  bus.res_exception, e.exc);
          end
          holding = 1'b0;
        end
      end
    end
  end

  // One complete operation. rdy_at: BUSY cycle index in which the unit
  // reports ready (>= TMO means never). wait_c: cycles res_ready stays low.
  task automatic do_op(bit is_div, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                       int rdy_at, logic [31:0] result, bit exc, int wait_c, bit preload);
    int   p0;
    res_t e;
    bus.req_valid  = 1'b1;
    bus.req_is_div = is_div;
    bus.req_opA    = a;
    bus.req_opB    = b;
    bus.req_rd     = rd;
    #1 check("stall_on_req", bus.stall, 1);
    step();                                   // START
    p0 = pulses;
    bus.req_valid      = 1'b0;
    bus.req_opA        = $urandom;
    bus.req_opB        = $urandom;
    bus.req_is_div     = ~is_div;
    bus.unit_resultRDY = 1'($urandom);        // stale, must be ignored
    bus.unit_exception = 1'($urandom);
    #1;
    check("ctrl_div",  bus.ctrl_div, is_div);
    check("ctrl_mult", bus.ctrl_mult, !is_div);
    check("operandA",  bus.unit_operandA, a);
    check("operandB",  bus.unit_operandB, b);
    check("stall_start", bus.stall, 1);
    step();                                   // BUSY index 0
    for (int i = 0; i < TMO; i++) begin
      bus.unit_resultRDY = (i == rdy_at);
      bus.unit_exception = (i == rdy_at) ? exc : 1'($urandom);
      bus.unit_result    = (i == rdy_at) ? result : $urandom;
      #1;
      check("stall_busy", bus.stall, 1);
      check("valid_busy", bus.res_valid, 0);
      check("operandA_busy", bus.unit_operandA, a);
      step();
      if (i == rdy_at) break;
    end
    // reference outcome from the operation's rules
    if (rdy_at < TMO && !exc) e = '{result, rd, 1'b0};
    else                      e = '{is_div ? 32'd5 : 32'd4, 5'd30, 1'b1};
    if (rdy_at >= TMO) exp_terr = 1'b1;
    exp_q.push_back(e);
    n_vec++;
    for (int w = 0; w < wait_c; w++) begin
      bus.res_ready      = 1'b0;
      bus.unit_resultRDY = 1'($urandom);
      bus.unit_exception = 1'($urandom);
      bus.unit_result    = $urandom;
      #1;
      check("valid_done", bus.res_valid, 1);
      check("stall_bp", bus.stall, 1);
      check("operandB_done", bus.unit_operandB, b);
      step();
    end
    bus.res_ready      = 1'b1;
    bus.unit_resultRDY = 1'b0;
    if (preload) begin
      bus.req_valid  = 1'b1;
      bus.req_is_div = 1'($urandom);
      bus.req_opA    = $urandom;
      bus.req_opB    = $urandom;
      bus.req_rd     = 5'($urandom);
    end
    #1;
    check("valid_accept", bus.res_valid, 1);
    check("stall_accept", bus.stall, 0);
    check("start_pulses", pulses, p0 + 1);
    step();                                   // IDLE
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("valid_idle", bus.res_valid, 0);
    check("timeout_err", bus.timeout_err, exp_terr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_is_div     = 1'b0;
    bus.req_opA        = '0;
    bus.req_opB        = '0;
    bus.req_rd         = '0;
    bus.unit_result    = '0;
    bus.unit_exception = 1'b0;
    bus.unit_resultRDY = 1'b0;
    bus.res_ready      = 1'b0;
    #2;
    check("rst_stall",   bus.stall, 0);
    check("rst_valid",   bus.res_valid, 0);
    check("rst_ctrl",    {bus.ctrl_mult, bus.ctrl_div}, 0);
    check("rst_opA",     bus.unit_operandA, 0);
    check("rst_data",    bus.res_data, 0);
    check("rst_terr",    bus.timeout_err, 0);
    step();
    step();
    reset = 1'b0;

    // directed cases
    do_op(1'b1, 32'd21, 32'd3, 5'd7, 2, 32'd7, 1'b0, 0, 1'b0);
    do_op(1'b1, 32'd10, 32'd0, 5'd9, 0, 32'hDEAD, 1'b1, 1, 1'b0);
    do_op(1'b0, 32'h4000_0000, 32'd4, 5'd12, 4, 32'd0, 1'b1, 0, 1'b0);
    do_op(1'b0, 32'd6, 32'd7, 5'd3, 1, 32'd42, 1'b0, 3, 1'b1);
    do_op(1'b1, 32'd100, 32'd7, 5'd4, 3, 32'd14, 1'b0, 0, 1'b0);
    do_op(1'b1, 32'd5, 32'd5, 5'd8, 100, 32'd1, 1'b0, 0, 1'b0);
    do_op(1'b0, 32'd3, 32'd9, 5'd11, TMO - 1, 32'd27, 1'b0, 2, 1'b0);

    // reset in the middle of BUSY
    bus.req_valid  = 1'b1;
    bus.req_is_div = 1'b1;
    bus.req_opA    = 32'd77;
    bus.req_opB    = 32'd7;
    bus.req_rd     = 5'd5;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("arst_stall", bus.stall, 0);
    check("arst_valid", bus.res_valid, 0);
    check("arst_ctrl",  {bus.ctrl_mult, bus.ctrl_div}, 0);
    check("arst_opA",   bus.unit_operandA, 0);
    check("arst_rd",    bus.res_rd, 0);
    check("arst_terr",  bus.timeout_err, 0);
    exp_terr = 1'b0;
    step();
    reset = 1'b0;
    p0 = pulses;
    bus.unit_resultRDY = 1'b1;
    bus.unit_result    = 32'd11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("late_rdy_valid", bus.res_valid, 0);
      check("late_rdy_stall", bus.stall, 0);
    end
    bus.unit_resultRDY = 1'b0;
    check("no_start_after_rst", pulses, p0);
    do_op(1'b0, 32'd8, 32'd8, 5'd1, 0, 32'd64, 1'b0, 0, 1'b0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)),
            int'($urandom_range(0, TMO + 1)), $urandom,
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_multdiv_issue_ctrl
`default_nettype wire
